// File: rtl/mac_vector_feeder.sv
// Initiator side of a MAC dot-product link: holds operand vectors, streams them
// one element per cycle into the MAC, then waits for and captures the result.
//
// state  | meaning
// IDLE   | register file writable; waiting for start
// STREAM | one operand pair driven to the MAC per cycle
// WAIT   | vector sent; waiting for MAC result or timeout
// DONE   | done pulse cycle; forces one idle MAC cycle between vectors
module mac_vector_feeder #(
   parameter int VEC_LEN = 8,
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       wr_en_i,
   input  logic [$clog2(VEC_LEN)-1:0] wr_addr_i,
   input  logic [DATA_W-1:0]          wr_input_i,
   input  logic [DATA_W-1:0]          wr_weight_i,
   input  logic [$clog2(VEC_LEN):0]   len_i,
   input  logic                       start_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       error_o,
   output logic [ACC_W-1:0]           result_o,
   output logic                       dsp_enable_o,
   output logic                       dsp_valid_o,
   output logic [DATA_W-1:0]          dsp_input_o,
   output logic [DATA_W-1:0]          dsp_weight_o,
   input  logic                       dsp_valid_i,
   input  logic [ACC_W-1:0]           dsp_output_i
);

   localparam int AW = $clog2(VEC_LEN);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

   state_t            state;
   logic [AW-1:0]     idx;
   logic [LW-1:0]     len_q;
   logic [TW-1:0]     timer;

   logic [DATA_W-1:0] mem_in [VEC_LEN];
   logic [DATA_W-1:0] mem_wt [VEC_LEN];

   logic [LW-1:0]     len_clamp;
   logic [LW-1:0]     len_last;
   logic [AW-1:0]     idx_nxt;
   logic              last_now;
   logic              wr_hit0;
   logic [DATA_W-1:0] first_in;
   logic [DATA_W-1:0] first_wt;

   always_comb begin
      len_clamp = (len_i > LW'(VEC_LEN)) ? LW'(VEC_LEN) : len_i;
      len_last  = len_q - LW'(1);
      idx_nxt   = idx + AW'(1);
      last_now  = ({1'b0, idx} == len_last);
      // element 0 is read in the start cycle, so bypass a same-cycle write to it
      wr_hit0   = wr_en_i && (wr_addr_i == '0);
      first_in  = wr_hit0 ? wr_input_i  : mem_in[0];
      first_wt  = wr_hit0 ? wr_weight_i : mem_wt[0];
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i && (state == IDLE)) begin
         mem_in[wr_addr_i] <= wr_input_i;
         mem_wt[wr_addr_i] <= wr_weight_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         idx          <= '0;
         len_q        <= '0;
         timer        <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
         result_o     <= '0;
         dsp_enable_o <= 1'b0;
         dsp_valid_o  <= 1'b0;
         dsp_input_o  <= '0;
         dsp_weight_o <= '0;
      end else begin
         done_o       <= 1'b0;
         error_o      <= 1'b0;
         dsp_enable_o <= 1'b0;
         dsp_valid_o  <= 1'b0;
         dsp_input_o  <= '0;
         dsp_weight_o <= '0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (len_i == '0) begin
                     done_o   <= 1'b1;
                     result_o <= '0;
                  end else begin
                     len_q        <= len_clamp;
                     idx          <= '0;
                     busy_o       <= 1'b1;
                     dsp_enable_o <= 1'b1;
                     dsp_valid_o  <= (len_clamp == LW'(1));
                     dsp_input_o  <= first_in;
                     dsp_weight_o <= first_wt;
                     state        <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (last_now) begin
                  timer <= '0;
                  state <= WAIT;
               end else begin
                  idx          <= idx_nxt;
                  dsp_enable_o <= 1'b1;
                  dsp_valid_o  <= ({1'b0, idx_nxt} == len_last);
                  dsp_input_o  <= mem_in[idx_nxt];
                  dsp_weight_o <= mem_wt[idx_nxt];
               end
            end
            WAIT: begin
               if (dsp_valid_i) begin
                  result_o <= dsp_output_i;
                  done_o   <= 1'b1;
                  busy_o   <= 1'b0;
                  state    <= DONE;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  error_o <= 1'b1;
                  busy_o  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
